// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port req/gnt arbiter in front of a single-port 256x8 RAM
// Sequences IDLE -> ACCESS (-> RDATA for reads); gnt, rvalid and ram_we are registered.
module mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       we0_i,
  input  logic       we1_i,
  input  logic [7:0] addr0_i,
  input  logic [7:0] addr1_i,
  input  logic [7:0] wdata0_i,
  input  logic [7:0] wdata1_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  output logic       rvalid0_o,
  output logic       rvalid1_o,
  output logic [7:0] rdata_o,
  output logic       busy_o,
  output logic [7:0] ram_addr_o,
  output logic [7:0] ram_data_o,
  output logic       ram_we_o,
  input  logic [7:0] ram_out_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RDATA = 2'd2} state_e;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       we_q, we_d;
  logic       last_q, last_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic       ram_we_q, ram_we_d;
  logic       take;
  logic       win;

  // On a tie, round-robin hands the slot to the port that was not served last.
  always_comb begin
    win = 1'b0;
    case ({req1_i, req0_i})
      2'b10:   win = 1'b1;
      2'b11:   win = FIXED_PRIO ? 1'b0 : ~last_q;
      default: win = 1'b0;
    endcase
  end

  assign take = (state_q == IDLE) && (req0_i || req1_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      ram_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      ram_we_q <= ram_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = ACCESS;
          owner_d = win;
          we_d    = win ? we1_i    : we0_i;
          addr_d  = win ? addr1_i  : addr0_i;
          wdata_d = win ? wdata1_i : wdata0_i;
        end
      end
      ACCESS: begin
        last_d  = owner_q;
        state_d = we_q ? IDLE : RDATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered strobes are computed from the state being entered.
  always_comb begin
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    ram_we_d = 1'b0;
    if (state_d == ACCESS) begin
      gnt_d[owner_d] = 1'b1;
      ram_we_d       = we_d;
    end
    if (state_d == RDATA) begin
      rvalid_d[owner_q] = 1'b1;
    end
  end

  assign gnt0_o     = gnt_q[0];
  assign gnt1_o     = gnt_q[1];
  assign rvalid0_o  = rvalid_q[0];
  assign rvalid1_o  = rvalid_q[1];
  assign rdata_o    = (|rvalid_q) ? ram_out_i : 8'h00;
  assign busy_o     = (state_q != IDLE);
  assign ram_addr_o = addr_q;
  assign ram_data_o = wdata_q;
  assign ram_we_o   = ram_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - bench for mem_arbiter, round-robin and fixed-priority instances side by side
// A transaction-level timeline model predicts grants, read data and busy windows.
module tb_mem_arbiter;

  localparam int FP_DUT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clr;
  logic [1:0] req   [2];
  logic [1:0] we    [2];
  logic [7:0] addr  [2][2];
  logic [7:0] wdata [2][2];
  logic       gnt0 [2], gnt1 [2], rv0 [2], rv1 [2], busy [2], ram_we [2];
  logic [7:0] rdata [2], ram_addr [2], ram_data [2], ram_out [2];
  logic [7:0] ram [2][256];

  mem_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_i(req[0][0]), .req1_i(req[0][1]), .we0_i(we[0][0]), .we1_i(we[0][1]),
    .addr0_i(addr[0][0]), .addr1_i(addr[0][1]), .wdata0_i(wdata[0][0]), .wdata1_i(wdata[0][1]),
    .gnt0_o(gnt0[0]), .gnt1_o(gnt1[0]), .rvalid0_o(rv0[0]), .rvalid1_o(rv1[0]),
    .rdata_o(rdata[0]), .busy_o(busy[0]), .ram_addr_o(ram_addr[0]), .ram_data_o(ram_data[0]),
    .ram_we_o(ram_we[0]), .ram_out_i(ram_out[0])
  );

  mem_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_i(req[1][0]), .req1_i(req[1][1]), .we0_i(we[1][0]), .we1_i(we[1][1]),
    .addr0_i(addr[1][0]), .addr1_i(addr[1][1]), .wdata0_i(wdata[1][0]), .wdata1_i(wdata[1][1]),
    .gnt0_o(gnt0[1]), .gnt1_o(gnt1[1]), .rvalid0_o(rv0[1]), .rvalid1_o(rv1[1]),
    .rdata_o(rdata[1]), .busy_o(busy[1]), .ram_addr_o(ram_addr[1]), .ram_data_o(ram_data[1]),
    .ram_we_o(ram_we[1]), .ram_out_i(ram_out[1])
  );

  // Registered-read RAM behind each arbiter.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (clr) begin
        for (int i = 0; i < 256; i++) ram[d][i] <= 8'h00;
        ram_out[d] <= 8'h00;
      end else begin
        if (ram_we[d]) ram[d][ram_addr[d]] <= ram_data[d];
        ram_out[d] <= ram[d][ram_addr[d]];
      end
    end
  end

  int         tests = 0;
  int         errors = 0;
  int         cyc = 0;
  int         free_at [2];
  int         g_cyc [2], r_cyc [2];
  int         g_port [2], r_port [2];
  bit         g_we [2];
  bit         last_gnt [2];
  bit         rst_seen [2];
  logic [7:0] r_data [2], lat_addr [2], lat_data [2];
  logic [7:0] mem [2][256];
  bit         hold = 1'b0;
  bit         rd_only = 1'b0;
  int         rnd_prob = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Timeline model: a request sampled at edge k is granted in cycle k, a read
  // returns in cycle k+1, and the port pair is sampled again at k+2 / k+3.
  task automatic model_edge(input int d);
    int w;
    rst_seen[d] = !rst_n;
    if (!rst_n) begin
      free_at[d]  = cyc + 1;
      last_gnt[d] = 1'b1;
      lat_addr[d] = 8'h00;
      lat_data[d] = 8'h00;
      g_cyc[d]    = -1;
      r_cyc[d]    = -1;
    end else if (cyc >= free_at[d] && req[d] != 2'b00) begin
      if (req[d] == 2'b01)      w = 0;
      else if (req[d] == 2'b10) w = 1;
      else if (d == FP_DUT)     w = 0;
      else                      w = last_gnt[d] ? 0 : 1;
      g_cyc[d]    = cyc;
      g_port[d]   = w;
      g_we[d]     = we[d][w];
      lat_addr[d] = addr[d][w];
      lat_data[d] = wdata[d][w];
      last_gnt[d] = (w == 1);
      if (g_we[d]) begin
        mem[d][lat_addr[d]] = lat_data[d];
        free_at[d] = cyc + 2;
      end else begin
        r_cyc[d]  = cyc + 1;
        r_port[d] = w;
        r_data[d] = mem[d][lat_addr[d]];
        free_at[d] = cyc + 3;
      end
    end
  endtask

  task automatic check_dut(input int d);
    logic [5:0] e, o;
    bit gn, rn;
    gn = (g_cyc[d] == cyc);
    rn = (r_cyc[d] == cyc);
    e = {gn && g_port[d] == 1, gn && g_port[d] == 0, rn && r_port[d] == 1, rn && r_port[d] == 0,
         gn && g_we[d], (cyc + 1) < free_at[d]};
    o = {gnt1[d], gnt0[d], rv1[d], rv0[d], ram_we[d], busy[d]};
    check_eq($sformatf("d%0d_flags", d), 32'(o), 32'(e));
    check_eq($sformatf("d%0d_ram_addr", d), 32'(ram_addr[d]), 32'(lat_addr[d]));
    check_eq($sformatf("d%0d_ram_data", d), 32'(ram_data[d]), 32'(lat_data[d]));
    check_eq($sformatf("d%0d_we_outside_gnt", d), 32'(ram_we[d] & ~(gnt0[d] | gnt1[d])), 32'd0);
    if (rn) check_eq($sformatf("d%0d_rdata", d), 32'(rdata[d]), 32'(r_data[d]));
    if (rst_seen[d]) check_eq($sformatf("d%0d_rdata_rst", d), 32'(rdata[d]), 32'd0);
  endtask

  task automatic new_attrs(input int d, input int p);
    we[d][p]    = rd_only ? 1'b0 : 1'($urandom_range(1));
    addr[d][p]  = 8'($urandom_range(15));
    wdata[d][p] = 8'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) model_edge(d);
    for (int d = 0; d < 2; d++) check_dut(d);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (p == 1 ? gnt1[d] : gnt0[d]) begin
          if (hold) new_attrs(d, p);
          else      req[d][p] = 1'b0;
        end
        if (rnd_prob > 0 && !req[d][p] && $urandom_range(99) < rnd_prob) begin
          req[d][p] = 1'b1;
          new_attrs(d, p);
        end
      end
    end
  endtask

  task automatic wait_gnt(input int d, input int p);
    for (int i = 0; i < 20; i++) begin
      step();
      if (p == 1 ? gnt1[d] : gnt0[d]) return;
    end
    check_eq($sformatf("d%0d_p%0d_gnt_timeout", d, p), 32'd0, 32'd1);
  endtask

  task automatic set_req(input int p, input bit w, input logic [7:0] a, input logic [7:0] v);
    for (int d = 0; d < 2; d++) begin
      req[d][p] = 1'b1; we[d][p] = w; addr[d][p] = a; wdata[d][p] = v;
    end
  endtask

  task automatic clear_reqs(input int n);
    for (int d = 0; d < 2; d++) req[d] = 2'b00;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int g0, g1, fg1;
    for (int d = 0; d < 2; d++) begin
      free_at[d] = 0; g_cyc[d] = -1; r_cyc[d] = -1; g_port[d] = 0; r_port[d] = 0;
      last_gnt[d] = 1'b1; lat_addr[d] = 8'h00; lat_data[d] = 8'h00; r_data[d] = 8'h00;
      for (int i = 0; i < 256; i++) mem[d][i] = 8'h00;
      req[d] = 2'b00; we[d] = 2'b00;
      for (int p = 0; p < 2; p++) begin addr[d][p] = 8'h00; wdata[d][p] = 8'h00; end
    end

    // Reset with both ports requesting, then release: port 0 wins the first tie.
    rst_n = 1'b0;
    clr   = 1'b1;
    set_req(0, 1'b1, 8'h01, 8'h11);
    set_req(1, 1'b1, 8'h02, 8'h22);
    step();
    step();
    clr   = 1'b0;
    rst_n = 1'b1;
    step();
    check_eq("first_gnt_rr", 32'({gnt1[0], gnt0[0]}), 32'd1);
    check_eq("first_gnt_fp", 32'({gnt1[1], gnt0[1]}), 32'd1);
    clear_reqs(4);

    // Port 0 write then read back.
    set_req(0, 1'b1, 8'h10, 8'hA5);
    wait_gnt(0, 0);
    check_eq("p0_wr_we", 32'(ram_we[0]), 32'd1);
    check_eq("p0_wr_addr", 32'(ram_addr[0]), 32'h10);
    set_req(0, 1'b0, 8'h10, 8'h00);
    wait_gnt(0, 0);
    step();
    check_eq("p0_rd_rvalid", 32'({rv1[0], rv0[0]}), 32'd1);
    check_eq("p0_rd_data", 32'(rdata[0]), 32'hA5);
    clear_reqs(3);

    // Both ports hold reads for 12 cycles.
    hold = 1'b1;
    rd_only = 1'b1;
    g0 = 0; g1 = 0; fg1 = 0;
    for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) begin req[d][p] = 1'b1; new_attrs(d, p); end
    for (int i = 0; i < 12; i++) begin
      step();
      if (gnt0[0]) g0++;
      if (gnt1[0]) g1++;
      if (gnt1[1]) fg1++;
    end
    check_eq("rr_gnt0_count", 32'(g0), 32'd2);
    check_eq("rr_gnt1_count", 32'(g1), 32'd2);
    check_eq("fp_gnt1_count", 32'(fg1), 32'd0);
    hold = 1'b0;
    rd_only = 1'b0;
    req[0] = 2'b00;
    req[1][0] = 1'b0;
    wait_gnt(FP_DUT, 1);
    clear_reqs(4);

    // Reset lands on the edge that would enter RDATA of a port 1 read.
    set_req(1, 1'b0, 8'h03, 8'h00);
    wait_gnt(0, 1);
    rst_n = 1'b0;
    step();
    check_eq("rst_mid_rv1_rr", 32'(rv1[0]), 32'd0);
    check_eq("rst_mid_rv1_fp", 32'(rv1[1]), 32'd0);
    rst_n = 1'b1;
    step();
    set_req(1, 1'b1, 8'h20, 8'h3C);
    wait_gnt(0, 1);
    set_req(1, 1'b0, 8'h20, 8'h00);
    wait_gnt(0, 1);
    step();
    check_eq("post_rst_rd", 32'(rdata[0]), 32'h3C);
    clear_reqs(3);

    // Port 1 arrives during port 0's ACCESS cycle.
    set_req(0, 1'b1, 8'h05, 8'h5A);
    wait_gnt(0, 0);
    set_req(1, 1'b0, 8'h05, 8'h00);
    step();
    check_eq("p1_held_off", 32'(gnt1[0]), 32'd0);
    wait_gnt(0, 1);
    step();
    check_eq("p1_rd_after_p0_wr", 32'(rdata[0]), 32'h5A);
    clear_reqs(3);

    // Random traffic with occasional resets.
    rnd_prob = 30;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(149) != 0);
      step();
    end
    hold = 1'b1;
    rnd_prob = 60;
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(149) != 0);
      step();
    end
    rst_n = 1'b1;
    hold = 1'b0;
    rnd_prob = 0;
    clear_reqs(4);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 256x8 RAM between the microprocessor (port 0) and a secondary bus master such as a program loader or DMA engine (port 1). Each master makes one access at a time through a req/gnt/rvalid handshake. The arbiter sequences every RAM cycle and is the only driver of the RAM din/addr/we inputs. It sits between the masters and the memory inside the microcomputer top level.

## Interface
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins a tie.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0, req1  in  1 each  access request; held high with its attributes stable until the matching gnt.
- we0, we1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  8 each  RAM address.
- wdata0, wdata1  in  8 each  write data.
- gnt0, gnt1  out  1 each  one-cycle pulse in the cycle the port's access is presented to the RAM.
- rvalid0, rvalid1  out  1 each  one-cycle pulse; rdata is valid for that port's read.
- rdata  out  8  read data, shared by both ports and qualified by rvalid.
- busy  out  1  high whenever the state is not IDLE.
- ram_addr  out  8  to RAM addr.
- ram_data  out  8  to RAM din.
- ram_we  out  1  to RAM we.
- ram_out  in  8  from RAM dout; registered read, so it reflects the address of the previous cycle.

## Operation
- There are three states: IDLE, ACCESS and RDATA.
- **IDLE.** If no req is high, stay in IDLE. Otherwise:
  - choose a winner;
  - latch the winner's addr, we and wdata into internal registers along with the owner id;
  - move to ACCESS.
- **Winner selection.**
  - Only one req high: that port wins.
  - Both high with FIXED_PRIO=1: port 0 wins.
  - Both high with FIXED_PRIO=0: the port not in the last-grant pointer wins.
- **ACCESS.**
  - ram_addr and ram_data come from the latched registers. ram_we equals the latched we.
  - gnt[owner] is high, and the last-grant pointer is updated to the owner.
  - Next state is IDLE for a write, RDATA for a read.
- **RDATA.**
  - rvalid[owner] is high and rdata equals ram_out.
  - Next state is IDLE.
- **Outside ACCESS:**
  - ram_we is 0;
  - ram_addr and ram_data hold their last latched values;
  - gnt0 and gnt1 are 0.
- Requests arriving in ACCESS or RDATA are not sampled until the state is IDLE. A req still high in IDLE after its gnt counts as a new request.
- **Reset** (rst_n=0 at a rising edge, in any state):
  - state → IDLE, last-grant pointer → 1, so port 0 wins the first tie;
  - latched addr/data/we → 0;
  - all outputs → 0: gnt, rvalid, rdata, busy, ram_addr, ram_data, ram_we;
  - a read in flight is dropped with no rvalid, and a write not yet in ACCESS is dropped.

## Timing
- Request sampled in IDLE at edge E:
  - gnt pulses in cycle E+1, which is also the RAM access cycle;
  - a write is committed at edge E+2;
  - for a read, rvalid and rdata are valid in cycle E+2.
- Occupancy: a write takes 2 cycles (IDLE, ACCESS) and a read takes 3 (IDLE, ACCESS, RDATA). Peak rate is one write per 2 cycles or one read per 3 cycles.
- A master that drops req on the edge after seeing gnt gets exactly one access. A master that keeps req high gets back-to-back accesses, subject to arbitration.
- With both ports continuously requesting and FIXED_PRIO=0, grants alternate 0,1,0,1. Worst-case wait for a port is one foreign access plus its own, i.e. 6 cycles for reads.
- With FIXED_PRIO=1, port 1 can starve; this is intended for loader-only use.
- gnt and rvalid are registered, glitch-free and never high for both ports in the same cycle.

## Test plan
- **Reset values:** hold rst_n=0 for 2 cycles with both req high → every output 0 and busy 0. Release → port 0 granted first.
- **Port 0 write then read:** write addr=0x10, wdata=0xA5 → gnt0 one cycle after the sampling edge with ram_we=1 and ram_addr=0x10. Then read addr=0x10 → rvalid0 two cycles after sampling with rdata=0xA5, and rvalid1 stays 0.
- **Round-robin (FIXED_PRIO=0):** both ports hold read requests for 12 cycles → grants go gnt0, gnt1, gnt0, gnt1, one every 3 cycles. Each rvalid goes to the matching port with that port's data.
- **Fixed priority (FIXED_PRIO=1):** both ports request continuously → only gnt0 pulses. Drop req0 → gnt1 follows on the next IDLE sample.
- **Reset mid-read:** assert rst_n=0 in the RDATA cycle of a port 1 read → no rvalid1, state IDLE, ram_we 0. A write issued after reset still completes correctly.
- **Simultaneous events:** port 1 raises req during port 0's ACCESS → port 1 is not granted until the next IDLE. ram_we is never high outside a gnt cycle; the bench asserts this every cycle.
